add2_operand_feeder: RTL

Upstream stage of the `add2` adder/subtractor. Accepts a byte stream over a valid/ready handshake and pairs consecutive bytes into (A, B) operands. Buffers complete pairs in a small FIFO and issues them to the adder's `add1`/`add2` inputs with a one-cycle `issue` strobe, honouring downstream back-pressure and a programmable minimum issue spacing.

---
 rtl/add2_operand_feeder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/add2_operand_feeder.sv
// add2_operand_feeder: pairs an incoming byte stream into (A, B) operands,
// buffers complete pairs and issues them to the add2 adder with spacing.
module add2_operand_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_flush,
    input  logic                              issue_ready,
    output logic [7:0]                        add1,
    output logic [7:0]                        add2,
    output logic                              issue,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]                  issued_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [LVL_W-1:0] DEPTH = LVL_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP   = GAP_W'(ISSUE_GAP);

    typedef enum logic {S_A, S_B} state_t;

    state_t           state;
    logic [7:0]       hold;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             wr_en;
    logic             pop;

    // Ready depends only on registered state; a same-cycle pop cannot raise it.
    assign in_ready = (state == S_A) || (fifo_level < DEPTH);
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept && (state == S_B) && !in_flush;
    assign pop      = (fifo_level != '0) && issue_ready
                      && (gap_cnt == '0) && !in_flush;

    // Pairing FSM: first byte is held as A, second completes the pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_A;
            hold  <= '0;
        end else if (in_flush) begin
            state <= S_A;
        end else if (accept) begin
            unique case (state)
                S_A: begin
                    hold  <= in_data;
                    state <= S_B;
                end
                S_B:     state <= S_A;
                default: state <= S_A;
            endcase
        end
    end

    // Pair storage; the read side never bypasses a same-cycle write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {hold, in_data};
        end
    end

    // FIFO pointers and occupancy, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || in_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Registered operands, issue strobe and issued-pair counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            add1       <= '0;
            add2       <= '0;
            issue      <= 1'b0;
            issued_cnt <= '0;
        end else begin
            issue <= pop;
            if (pop) begin
                {add1, add2} <= mem[rd_ptr];
                issued_cnt   <= issued_cnt + 1'b1;
            end
        end
    end

    // Minimum spacing between issues; flush leaves it running.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (pop) begin
            gap_cnt <= GAP;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule
